// File: rtl/sort_pkg.sv
// ============================================================================
// sort_pkg : shared sizes, checker state encoding and error-bit indices
// Rev 1.0
// ============================================================================
`default_nettype none

package sort_pkg;

  localparam int SORT_AW    = 4;
  localparam int SORT_DW    = 8;
  localparam int SORT_DEPTH = 2 ** SORT_AW;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    CHECK   = 2'd1,
    REPORT  = 2'd2
  } state_e;

  // Bit positions inside the packed error-flag vector
  localparam int ERR_ORDER   = 0;
  localparam int ERR_MISSING = 1;
  localparam int ERR_DUP     = 2;
  localparam int ERR_LATE    = 3;
  localparam int ERR_W       = 4;

endpackage

`default_nettype wire

// File: rtl/sink_store.sv
// ============================================================================
// sink_store : DEPTH x DW register array, one write port, registered read
//              port and a combinational (idx-1, idx) greater-than compare
// Rev 1.0
// ============================================================================
`default_nettype none

module sink_store
  import sort_pkg::*;
#(
  parameter int AW    = SORT_AW,
  parameter int DW    = SORT_DW,
  parameter int DEPTH = SORT_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o,
  input  logic [AW-1:0] cmp_idx_i,
  output logic          cmp_gt_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Contents survive reset; only the read register is cleared
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o  = rdata_q;
  assign cmp_gt_o = mem_q[cmp_idx_i - AW'(1)] > mem_q[cmp_idx_i];

endmodule

`default_nettype wire

// File: rtl/iram_sink_checker.sv
// ============================================================================
// iram_sink_checker : captures sorter IRAM writes, then scans the result
//                     store for non-decreasing order and reports pass/fail
// Rev 1.0
// ============================================================================
`default_nettype none

module iram_sink_checker
  import sort_pkg::*;
#(
  parameter int AW = SORT_AW,
  parameter int DW = SORT_DW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             IRAM_valid,
  input  logic [AW-1:0]    IRAM_A,
  input  logic [DW-1:0]    IRAM_D,
  input  logic             done,
  input  logic [AW-1:0]    rd_addr,
  output logic [DW-1:0]    rd_data,
  output logic [AW:0]      wr_count,
  output logic [DW+AW-1:0] sum_out,
  output logic             check_busy,
  output logic             check_done,
  output logic             pass,
  output logic             err_order,
  output logic             err_missing,
  output logic             err_dup,
  output logic             err_late
);

  localparam int          DEPTH   = 2 ** AW;
  localparam logic [AW:0] CNT_MAX = '1;

  state_e             state_q;
  logic               done_q;
  logic [DEPTH-1:0]   written_q;
  logic [DEPTH-1:0]   written_d;
  logic [AW-1:0]      idx_q;
  logic [AW:0]        wr_count_q;
  logic [DW+AW-1:0]   sum_q;
  logic               busy_q;
  logic               cdone_q;
  logic               pass_q;
  logic [ERR_W-1:0]   err_q;
  logic [ERR_W-1:0]   err_d;

  logic               wr_en;
  logic               store_we;
  logic               rise;
  logic               cmp_gt;

  assign wr_en    = IRAM_valid && (state_q == COLLECT);
  assign store_we = wr_en && !reset;
  assign rise     = done && !done_q && (state_q == COLLECT);

  sink_store #(
    .AW    (AW),
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_store (
    .clk       (clk),
    .reset     (reset),
    .we_i      (store_we),
    .waddr_i   (IRAM_A),
    .wdata_i   (IRAM_D),
    .raddr_i   (rd_addr),
    .rdata_o   (rd_data),
    .cmp_idx_i (idx_q),
    .cmp_gt_o  (cmp_gt)
  );

  // Next-state coverage and flags; a write in the rise cycle counts toward coverage
  always_comb begin
    written_d = written_q;
    err_d     = err_q;
    if (wr_en) begin
      written_d[IRAM_A] = 1'b1;
      if (written_q[IRAM_A]) begin
        err_d[ERR_DUP] = 1'b1;
      end
    end
    if (IRAM_valid && (state_q != COLLECT)) begin
      err_d[ERR_LATE] = 1'b1;
    end
    if (rise) begin
      err_d[ERR_MISSING] = ~&written_d;
    end
    if ((state_q == CHECK) && cmp_gt) begin
      err_d[ERR_ORDER] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= COLLECT;
      done_q     <= 1'b0;
      written_q  <= '0;
      idx_q      <= '0;
      wr_count_q <= '0;
      sum_q      <= '0;
      busy_q     <= 1'b0;
      cdone_q    <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
    end else begin
      done_q    <= done;
      written_q <= written_d;
      err_q     <= err_d;
      if (wr_en) begin
        if (wr_count_q != CNT_MAX) begin
          wr_count_q <= wr_count_q + (AW+1)'(1);
        end
        sum_q <= sum_q + (DW+AW)'(IRAM_D);
      end
      case (state_q)
        COLLECT: begin
          if (rise) begin
            state_q <= CHECK;
            idx_q   <= AW'(1);
            busy_q  <= 1'b1;
          end
        end
        CHECK: begin
          idx_q <= idx_q + AW'(1);
          // Verdict includes the final pair compared in this same cycle
          if (idx_q == AW'(DEPTH - 1)) begin
            state_q <= REPORT;
            busy_q  <= 1'b0;
            cdone_q <= 1'b1;
            pass_q  <= ~|err_d;
          end
        end
        REPORT: begin
          state_q <= REPORT;
        end
        default: begin
          state_q <= COLLECT;
        end
      endcase
    end
  end

  assign wr_count    = wr_count_q;
  assign sum_out     = sum_q;
  assign check_busy  = busy_q;
  assign check_done  = cdone_q;
  assign pass        = pass_q;
  assign err_order   = err_q[ERR_ORDER];
  assign err_missing = err_q[ERR_MISSING];
  assign err_dup     = err_q[ERR_DUP];
  assign err_late    = err_q[ERR_LATE];

endmodule

`default_nettype wire

// File: tb/tb_iram_sink_checker.sv
// ============================================================================
// tb_iram_sink_checker : randomized stimulus with a reference-model scoreboard
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_iram_sink_checker;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          IRAM_valid = 1'b0;
  logic [AW-1:0] IRAM_A = '0;
  logic [DW-1:0] IRAM_D = '0;
  logic          done = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic [AW:0]   wr_count;
  logic [DW+AW-1:0] sum_out;
  logic check_busy, check_done, pass;
  logic err_order, err_missing, err_dup, err_late;

  iram_sink_checker #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .IRAM_valid(IRAM_valid), .IRAM_A(IRAM_A),
    .IRAM_D(IRAM_D), .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_count(wr_count), .sum_out(sum_out), .check_busy(check_busy),
    .check_done(check_done), .pass(pass), .err_order(err_order),
    .err_missing(err_missing), .err_dup(err_dup), .err_late(err_late)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: what the store holds and how each address was written
  logic [7:0] mem_m   [16];
  bit         known_m [16];
  int         cnt_m   [16];
  int         total_m;
  int         sum_m;
  bit         late_m;

  typedef struct {
    bit pass;
    bit e_ord;
    bit e_mis;
    bit e_dup;
    bit e_late;
    int wrc;
    int sum;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
    int         gap;
  } op_t;
  op_t ops_q[$];

  int done_cyc = 0;

  task automatic model_clear();
    for (int a = 0; a < 16; a++) cnt_m[a] = 0;
    total_m = 0;
    sum_m   = 0;
    late_m  = 0;
  endtask

  function automatic exp_t model_report();
    exp_t e;
    e.e_ord = 0; e.e_mis = 0; e.e_dup = 0;
    for (int a = 0; a < 16; a++) begin
      if (cnt_m[a] == 0) e.e_mis = 1;
      if (cnt_m[a] > 1)  e.e_dup = 1;
    end
    for (int a = 1; a < 16; a++)
      if (mem_m[a-1] > mem_m[a]) e.e_ord = 1;
    e.e_late = late_m;
    e.pass   = !(e.e_ord || e.e_mis || e.e_dup || e.e_late);
    e.wrc    = (total_m > 31) ? 31 : total_m;
    e.sum    = sum_m % 4096;
    return e;
  endfunction

  function automatic logic [7:0] plan_data(input int a);
    return (a == 15) ? 8'hFF : 8'((a + 1) * 16);
  endfunction

  task automatic add_op(input logic [3:0] a, input logic [7:0] d, input int gap);
    op_t o;
    o.a = a; o.d = d; o.gap = gap;
    ops_q.push_back(o);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic raise_done(input bit push);
    if (push) exp_q.push_back(model_report());
    done     = 1'b1;
    done_cyc = cyc;
  endtask

  // Readback is pointed at the written address: must return the pre-write data
  task automatic write_op(input logic [3:0] a, input logic [7:0] d, input bit with_done, input bit push);
    logic [7:0] old;
    bit k;
    old = mem_m[a];
    k   = known_m[a];
    IRAM_valid = 1'b1; IRAM_A = a; IRAM_D = d; rd_addr = a;
    mem_m[a] = d; known_m[a] = 1; cnt_m[a]++; total_m++; sum_m += int'(d);
    if (with_done) raise_done(push);
    tick();
    IRAM_valid = 1'b0;
    if (k) check("read_before_write", rd_data, old);
  endtask

  task automatic run_round(input bit done_with_last, input bit push);
    int n;
    n = ops_q.size();
    for (int i = 0; i < n; i++) begin
      write_op(ops_q[i].a, ops_q[i].d, done_with_last && (i == n - 1), push);
      if (!(done_with_last && (i == n - 1)))
        repeat (ops_q[i].gap) tick();
    end
    if (!done_with_last) begin
      raise_done(push);
      tick();
    end
  endtask

  task automatic wait_report();
    int n;
    n = 0;
    while (!check_done && n < 40) begin
      tick();
      n++;
    end
    check("report_reached", check_done, 1);
    @(negedge clk);
    #1;
  endtask

  task automatic check_zero_state(input string tag);
    check({tag, "_wr_count"}, wr_count, 0);
    check({tag, "_sum_out"}, sum_out, 0);
    check({tag, "_check_busy"}, check_busy, 0);
    check({tag, "_check_done"}, check_done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err_flags"}, {err_order, err_missing, err_dup, err_late}, 0);
    check({tag, "_rd_data"}, rd_data, 0);
  endtask

  task automatic do_reset(input bit check_vals);
    reset = 1'b1; done = 1'b0; IRAM_valid = 1'b0;
    tick();
    model_clear();
    if (check_vals) check_zero_state("reset");
    tick();
    reset = 1'b0;
  endtask

  task automatic readback(input int n);
    logic [3:0] a;
    for (int i = 0; i < n; i++) begin
      a = 4'($urandom_range(0, 15));
      rd_addr = a;
      tick();
      if (known_m[a]) check("readback", rd_data, mem_m[a]);
    end
  endtask

  task automatic build_plan(input int skip, input int swap);
    logic [7:0] d;
    ops_q.delete();
    for (int a = 15; a >= 0; a--) begin
      d = plan_data(a);
      if (swap && a == 5) d = plan_data(6);
      if (swap && a == 6) d = plan_data(5);
      if (a != skip) add_op(4'(a), d, 1);
    end
  endtask

  task automatic build_random(input int kind);
    logic [7:0] vals [16];
    int perm [16];
    int j, tmp, skip;
    logic [7:0] t8;
    for (int i = 0; i < 16; i++) begin
      vals[i] = 8'($urandom_range(0, 255));
      perm[i] = i;
    end
    if (kind != 1)
      for (int i = 0; i < 15; i++)
        for (int k = 0; k < 15 - i; k++)
          if (vals[k] > vals[k+1]) begin
            t8 = vals[k]; vals[k] = vals[k+1]; vals[k+1] = t8;
          end
    for (int i = 15; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    skip = (kind == 2) ? int'($urandom_range(0, 15)) : -1;
    ops_q.delete();
    for (int i = 0; i < 16; i++)
      if (perm[i] != skip) add_op(4'(perm[i]), vals[perm[i]], int'($urandom_range(0, 2)));
    if (kind == 3) begin
      j = int'($urandom_range(0, 15));
      add_op(4'(j), vals[j], 0);
    end
    if (kind == 4)
      repeat (20) begin
        j = int'($urandom_range(0, 15));
        add_op(4'(j), vals[j], 0);
      end
  endtask

  // Monitor: pops an expected report whenever the DUT presents check_done
  initial begin : monitor
    exp_t e;
    int busy_cnt;
    bit cd_prev;
    busy_cnt = 0;
    cd_prev  = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy_cnt = 0;
        cd_prev  = 0;
      end else begin
        if (check_busy) busy_cnt++;
        if (check_done && !cd_prev) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_report: got check_done=1, expected no report pending");
          end else begin
            e = exp_q.pop_front();
            check("rpt_pass", pass, e.pass);
            check("rpt_err_order", err_order, e.e_ord);
            check("rpt_err_missing", err_missing, e.e_mis);
            check("rpt_err_dup", err_dup, e.e_dup);
            check("rpt_err_late", err_late, e.e_late);
            check("rpt_wr_count", wr_count, e.wrc);
            check("rpt_sum_out", sum_out, e.sum);
            check("rpt_busy_cycles", busy_cnt, 15);
            check("rpt_latency", cyc - done_cyc, 16);
            check("rpt_busy_low", check_busy, 0);
          end
          busy_cnt = 0;
        end
        cd_prev = check_done;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    for (int a = 0; a < 16; a++) begin
      mem_m[a]   = 8'h00;
      known_m[a] = 0;
    end
    model_clear();
    do_reset(1);

    // Ascending data written in descending-address order
    build_plan(-1, 0);
    run_round(0, 1);
    wait_report();
    check("plan_pass", pass, 1);
    check("plan_wr_count", wr_count, 16);
    check("plan_sum", sum_out, 12'h87F);
    readback(3);
    do_reset(0);

    // Addresses 5 and 6 swapped
    build_plan(-1, 1);
    run_round(0, 1);
    wait_report();
    check("swap_err_order", err_order, 1);
    check("swap_pass", pass, 0);
    check("swap_other_errs", {err_missing, err_dup, err_late}, 0);
    do_reset(0);

    // Address 7 never written
    build_plan(7, 0);
    run_round(0, 1);
    wait_report();
    check("skip_err_missing", err_missing, 1);
    check("skip_wr_count", wr_count, 15);
    check("skip_pass", pass, 0);
    do_reset(0);

    // Address 3 written twice
    ops_q.delete();
    for (int a = 15; a >= 0; a--) begin
      if (a == 3) begin
        add_op(4'd3, 8'h30, 1);
        add_op(4'd3, 8'h31, 1);
      end else begin
        add_op(4'(a), plan_data(a), 1);
      end
    end
    run_round(0, 1);
    wait_report();
    check("dup_err_dup", err_dup, 1);
    check("dup_wr_count", wr_count, 17);
    rd_addr = 4'd3;
    tick();
    check("dup_readback", rd_data, 8'h31);
    do_reset(0);

    // Last write coincides with done rising, then a late write in REPORT
    build_plan(-1, 0);
    run_round(1, 1);
    wait_report();
    check("same_cycle_err_missing", err_missing, 0);
    check("same_cycle_pass", pass, 1);
    IRAM_valid = 1'b1; IRAM_A = 4'd0; IRAM_D = 8'h5A; rd_addr = 4'd0;
    late_m = 1;
    tick();
    IRAM_valid = 1'b0;
    tick();
    check("late_err_late", err_late, 1);
    check("late_pass_held", pass, 1);
    check("late_wr_count", wr_count, 16);
    check("late_sum", sum_out, 12'h87F);
    check("late_store_kept", rd_data, 8'h10);
    do_reset(0);

    // Reset lands in the 5th CHECK cycle
    build_plan(-1, 0);
    add_op(4'd9, plan_data(9), 0);
    run_round(0, 0);
    repeat (4) tick();
    check("midchk_busy", check_busy, 1);
    check("midchk_err_dup", err_dup, 1);
    reset = 1'b1; done = 1'b0;
    tick();
    model_clear();
    check_zero_state("midchk");
    tick();
    reset = 1'b0;

    ops_q.delete();
    for (int a = 0; a < 16; a++) add_op(4'(a), plan_data(a), int'($urandom_range(0, 2)));
    run_round(0, 1);
    wait_report();
    check("fresh_pass", pass, 1);
    do_reset(0);

    // Randomized rounds: sorted, unsorted, skipped, duplicated, saturating
    for (int r = 0; r < 10; r++) begin
      build_random(r % 5);
      run_round(bit'($urandom_range(0, 1)), 1);
      wait_report();
      readback(3);
      do_reset(0);
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/iram_sink_checker.md
Name: iram_sink_checker

Overview:
- Responder at the far end of the sorter's IRAM write-only interface (IRAM_valid/IRAM_A/IRAM_D/done).
- Captures every write into a 16x8 result store and tracks address coverage and a running data sum.
- After done rises, sequentially verifies the stored result is non-decreasing by address and reports pass/fail.
- Provides a registered readback port to the system bench/host.

Parameters:
- AW, 4, address width; DEPTH = 2**AW entries
- DW, 8, data width

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- IRAM_valid  input  1  write strobe from sorter, sampled every cycle
- IRAM_A  input  AW  write address
- IRAM_D  input  DW  write data
- done  input  1  sorter completion level
- rd_addr  input  AW  readback address
- rd_data  output  DW  mem[rd_addr], registered, 1-cycle latency
- wr_count  output  AW+1  accepted writes, saturating at 2**(AW+1)-1
- sum_out  output  DW+AW  modulo sum of all accepted write data
- check_busy  output  1  high while in CHECK
- check_done  output  1  high in REPORT
- pass  output  1  valid only when check_done; 1 = no error flags set
- err_order  output  1  sticky: some mem[i-1] > mem[i]
- err_missing  output  1  sticky: an address was never written
- err_dup  output  1  sticky: an address was written more than once
- err_late  output  1  sticky: IRAM_valid seen in CHECK or REPORT

Behaviour:
- Clock clk only; reset synchronous active-high, takes priority over all other actions in the same cycle.
- Reset values: rd_data=0, wr_count=0, sum_out=0, check_busy=0, check_done=0, pass=0, all err_*=0, written[] all 0, done_q=0, state=COLLECT. Store contents are not cleared.
- States:
  - COLLECT: accept writes.
  - CHECK: order scan.
  - REPORT: terminal, held until reset.
- COLLECT write, on IRAM_valid=1:
  - mem[IRAM_A] <= IRAM_D; written[IRAM_A] <= 1.
  - If written[IRAM_A] was already 1, set err_dup; the data still overwrites.
  - wr_count +1 (saturating); sum_out += IRAM_D, wrapping.
- Done detect: done_q registers done; rise = done & ~done_q, evaluated in COLLECT only.
  - On rise: go to CHECK, scan index i <= 1, err_missing <= ~&written. The value computed includes a write accepted in that same cycle.
  - Write and done rise in the same cycle: the write is accepted first, then the state changes.
  - done high out of reset: counts as a rise on the first post-reset cycle.
- CHECK: one compare per cycle.
  - If mem[i-1] > mem[i], set err_order; i increments.
  - After i = DEPTH-1 is compared, go to REPORT.
  - CHECK lasts exactly DEPTH-1 cycles; check_done is asserted DEPTH cycles after the rise cycle.
- REPORT: check_done=1; pass = ~(err_order|err_missing|err_dup|err_late), registered on REPORT entry.
- IRAM_valid in CHECK/REPORT: store and counters unchanged, err_late set.
- Comparison is unsigned.
- Readback: rd_data <= mem[rd_addr] every cycle in all states. Same-cycle write to the same address returns the old data (read-before-write).
- Reset mid-CHECK or mid-REPORT: immediate return to COLLECT with all flags cleared.

Decomposition:
- Shared package sort_pkg:
  - AW/DW defaults and DEPTH.
  - State enum: COLLECT, CHECK, REPORT.
  - Error-bit index constants, shared with sorter benches.
- One natural sub-module, sink_store: DEPTH x DW register array with one write port, one registered read port and one combinational pair-compare port (i-1, i).

Test Plan:
- Write values 0x10,0x20,..,0xF0,0xFF to addresses 0..15 in descending-address order with 1 idle cycle between writes, then raise done:
  - check_busy for 15 cycles; check_done 16 cycles after the rise.
  - pass=1, wr_count=16, sum_out=0x087F.
- Same as above but swap the data at addresses 5 and 6 -> err_order=1, pass=0, other err_*=0.
- Skip address 7 (15 writes) then done -> err_missing=1, wr_count=15, pass=0.
- Write address 3 twice (0x30 then 0x31), all others once -> err_dup=1, wr_count=17, rd_addr=3 returns 0x31.
- Final write (address 0) in the same cycle done rises -> the write is counted, err_missing=0, pass=1. A further IRAM_valid in REPORT -> err_late=1, pass unchanged.
- Assert reset during the 5th CHECK cycle -> next cycle: check_busy=0, all err_*=0, wr_count=0. A fresh full sequence then passes.
